// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words, queues them in a small FIFO
// and streams them to instruction memory through an auto-incrementing write port.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BASE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_cls,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [2:0]              in_funct3,
  input  logic                    in_alt,
  input  logic [12:0]             in_imm,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]       fifo_q [DEPTH];
  logic [31:0]       fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept, push, pop;

  // Field packing per instruction class
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_cls)
      3'd0: enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      3'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      3'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      3'd3: enc_word = {(in_alt ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1, in_funct3,
                        in_rd, 7'b0110011};
      3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      default: enc_legal = 1'b0;
    endcase
  end

  assign accept = in_valid && ready_q;
  assign push   = accept && enc_legal && !clear;
  assign pop    = we_q && mem_ready && !clear;

  // FIFO, address counter and registered output next-state
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = ADDR_W'(BASE);
    end else begin
      err_d = accept && !enc_legal;
      if (push) begin
        fifo_d[wr_ptr_q] = enc_word;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        addr_d   = addr_q + ADDR_W'(4);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    we_d    = (count_d != '0);
    ready_d = (count_d < CW'(DEPTH));
    wdata_d = we_d ? fifo_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_W'(BASE);
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, illegal class,
// address wrap, clear priority and asynchronous reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cls;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [12:0] in_imm;
  logic        mem_we;
  logic        mem_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  instr_encoder #(.DEPTH(4), .ADDR_W(12), .BASE(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_alt(in_alt), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Log every write that will complete at the coming rising edge
  always @(negedge clk) begin
    if (!rst && !clear && mem_we && mem_ready) begin
      wq_addr.push_back(32'(mem_addr));
      wq_data.push_back(mem_wdata);
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                      input logic [12:0] imm);
    bit done = 0;
    in_cls = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_alt = alt; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk_eq("push_accept", 32'(done), 32'd1);
  endtask

  task automatic addi(input logic [4:0] rd, input logic [11:0] imm);
    push(3'd2, rd, 5'd0, 5'd0, 3'd0, 1'b0, {1'b0, imm});
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (count == 0 && !mem_we) done = 1;
      else tick();
    end
    chk_eq("drain_done", 32'(done), 32'd1);
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk_eq({tag, "_present"}, 32'(wq_addr.size() != 0), 32'd1);
    if (wq_addr.size() != 0) begin
      chk_eq({tag, "_addr"}, wq_addr.pop_front(), a);
      chk_eq({tag, "_data"}, wq_data.pop_front(), d);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_cls = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_alt = 1'b0; in_imm = '0;
    tick(); tick();
    chk_eq("rst_count", 32'(count), 32'd0);
    chk_eq("rst_addr", 32'(mem_addr), 32'h0);
    chk_eq("rst_we", 32'(mem_we), 32'd0);
    chk_eq("rst_wdata", mem_wdata, 32'h0);
    chk_eq("rst_err", 32'(err), 32'd0);
    chk_eq("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // 1: LOAD latency and address step
    mem_ready = 1'b1;
    push(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8);
    chk_eq("t1_we", 32'(mem_we), 32'd1);
    chk_eq("t1_wdata", mem_wdata, 32'h00812283);
    chk_eq("t1_addr", 32'(mem_addr), 32'h000);
    tick();
    chk_eq("t1_addr_next", 32'(mem_addr), 32'h004);
    chk_eq("t1_we_off", 32'(mem_we), 32'd0);

    // 2: STORE and OP back to back
    do_clear();
    push(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 13'd12);
    push(3'd3, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
    push(3'd3, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0);
    drain();
    expect_write("t2_store", 32'h000, 32'h00612623);
    expect_write("t2_add", 32'h004, 32'h002081B3);
    expect_write("t2_sub", 32'h008, 32'h402081B3);

    // 3: branches, positive and negative offset
    do_clear();
    push(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd8);
    push(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'h1FF8);
    drain();
    expect_write("t3_bpos", 32'h000, 32'h00000463);
    expect_write("t3_bneg", 32'h004, 32'hFE000CE3);

    // 4: backpressure with a full FIFO
    do_clear();
    mem_ready = 1'b0;
    addi(5'd1, 12'd1);
    addi(5'd2, 12'd2);
    addi(5'd3, 12'd3);
    addi(5'd4, 12'd4);
    chk_eq("t4_full_count", 32'(count), 32'd4);
    chk_eq("t4_full_ready", 32'(in_ready), 32'd0);
    in_cls = 3'd2; in_rd = 5'd5; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 13'd5;
    in_valid = 1'b1;
    tick(); tick(); tick();
    chk_eq("t4_held_count", 32'(count), 32'd4);
    chk_eq("t4_stable_wdata", mem_wdata, 32'h00100093);
    chk_eq("t4_stable_addr", 32'(mem_addr), 32'h000);
    chk_eq("t4_ready_before_pop", 32'(in_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk_eq("t4_pop_count", 32'(count), 32'd3);
    chk_eq("t4_ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_eq("t4_refill_count", 32'(count), 32'd3);
    drain();
    expect_write("t4_w0", 32'h000, 32'h00100093);
    expect_write("t4_w1", 32'h004, 32'h00200113);
    expect_write("t4_w2", 32'h008, 32'h00300193);
    expect_write("t4_w3", 32'h00C, 32'h00400213);
    expect_write("t4_w4", 32'h010, 32'h00500293);

    // 5: illegal class followed by a legal OPIMM
    do_clear();
    push(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd1);
    chk_eq("t5_err_pulse", 32'(err), 32'd1);
    chk_eq("t5_ill_count", 32'(count), 32'd0);
    chk_eq("t5_ill_we", 32'(mem_we), 32'd0);
    addi(5'd1, 12'd5);
    chk_eq("t5_err_clear", 32'(err), 32'd0);
    chk_eq("t5_ok_count", 32'(count), 32'd1);
    drain();
    expect_write("t5_addi", 32'h000, 32'h00500093);
    chk_eq("t5_only_one", 32'(wq_addr.size()), 32'd0);

    // 6: address wrap at the top of the 12-bit space
    do_clear();
    for (int i = 0; i < 1022; i++) addi(5'd1, 12'd1);
    drain();
    chk_eq("t6_pre_addr", 32'(mem_addr), 32'hFF8);
    wq_addr.delete();
    wq_data.delete();
    mem_ready = 1'b0;
    addi(5'd1, 12'd1);
    addi(5'd2, 12'd2);
    addi(5'd3, 12'd3);
    chk_eq("t6_queued", 32'(count), 32'd3);
    mem_ready = 1'b1;
    drain();
    expect_write("t6_w0", 32'hFF8, 32'h00100093);
    expect_write("t6_w1", 32'hFFC, 32'h00200113);
    expect_write("t6_w2", 32'h000, 32'h00300193);
    chk_eq("t6_wrapped_addr", 32'(mem_addr), 32'h004);

    // clear together with push and a completing write
    mem_ready = 1'b0;
    addi(5'd1, 12'd1);
    addi(5'd2, 12'd2);
    in_cls = 3'd2; in_rd = 5'd7; in_imm = 13'd7; in_valid = 1'b1;
    mem_ready = 1'b1;
    clear = 1'b1;
    chk_eq("t6_clr_handshake", 32'(in_ready), 32'd1);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk_eq("t6_clr_count", 32'(count), 32'd0);
    chk_eq("t6_clr_addr", 32'(mem_addr), 32'h000);
    chk_eq("t6_clr_we", 32'(mem_we), 32'd0);
    chk_eq("t6_clr_nowrite", 32'(wq_addr.size()), 32'd0);
    tick();
    chk_eq("t6_clr_stays", 32'(count), 32'd0);

    // asynchronous reset mid-drain
    mem_ready = 1'b0;
    addi(5'd1, 12'd1);
    addi(5'd2, 12'd2);
    addi(5'd3, 12'd3);
    mem_ready = 1'b1;
    tick();
    #3 rst = 1'b1;
    #1;
    chk_eq("t6_rst_count", 32'(count), 32'd0);
    chk_eq("t6_rst_we", 32'(mem_we), 32'd0);
    chk_eq("t6_rst_addr", 32'(mem_addr), 32'h000);
    chk_eq("t6_rst_wdata", mem_wdata, 32'h0);
    chk_eq("t6_rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    push(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 13'd8);
    drain();
    expect_write("t6_post_rst", 32'h000, 32'h00812283);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the core's opcode decoder. Accepts decoded instruction fields over a valid/ready handshake and packs them into RV32I instruction words.
- Buffers encoded words in a small FIFO.
- Writes them sequentially into instruction memory through an auto-incrementing write port.
- Used by the program loader and by testbenches that generate JPEG-kernel programs on the fly.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 12, byte-address width of the instruction memory write port.
- BASE, 0, byte address of the first write after reset or clear; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous flush: empties the FIFO and reloads the address counter.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_cls  input  3  instruction class: 0 LOAD, 1 STORE, 2 OPIMM, 3 OP, 4 BRANCH, 5-7 illegal.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3; used by OPIMM, OP and BRANCH only.
- in_alt  input  1  OP only: selects funct7 = 0100000 (sub/sra); otherwise funct7 = 0000000.
- in_imm  input  13  immediate. I/S-type use bits [11:0]; B-type uses [12:1], and bit 0 is ignored.
- mem_we  output  1  write request.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_addr  output  ADDR_W  byte address of the current write.
- mem_wdata  output  32  encoded instruction word.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- err  output  1  one-cycle pulse when an illegal class is accepted.

Behaviour:
- Reset values: FIFO empty, count=0, mem_addr=BASE, mem_we=0, mem_wdata=0, err=0, in_ready=1.

Input handshake:
- A bundle is accepted at an edge where in_valid && in_ready.
- in_ready = (count < DEPTH); it is a registered function of count, with no combinational path from mem_ready.
- Encoding is combinational; the word is written into the FIFO at the accepting edge.

Encoding (opc = opcode):
- LOAD: opc 0000011, I-type, funct3 forced to 010.
  - Word = {imm[11:0], rs1, 010, rd, opc}.
- STORE: opc 0100011, S-type, funct3 forced to 010.
  - Word = {imm[11:5], rs2, rs1, 010, imm[4:0], opc}.
- OPIMM: opc 0010011, I-type with in_funct3.
- OP: opc 0110011.
  - Word = {funct7, rs2, rs1, funct3, rd, opc}.
- BRANCH: opc 1100011.
  - Word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}.
- Illegal class (5-7): the bundle is accepted (in_ready unchanged) but nothing is pushed. err is high for exactly the next cycle.

Output side:
- mem_we = (count != 0).
- mem_wdata = FIFO head; mem_addr = address counter.
- A write completes at an edge with mem_we && mem_ready. At that edge the head is popped and mem_addr += 4.
- mem_addr wraps modulo 2^ADDR_W; no error is flagged on wrap.
- mem_wdata and mem_addr must hold stable while mem_we && !mem_ready.
- Latency: a word accepted at edge N is presented with mem_we=1 in cycle N+1, or later if words are queued ahead of it.

Simultaneous events:
- Push and pop at the same edge: count is unchanged.
- When full, a pop at an edge raises in_ready in the following cycle only; no same-cycle refill.
- clear has priority over push, pop and err.
  - FIFO is emptied and mem_addr is set to BASE.
  - Any bundle presented that cycle is dropped, even if handshaked.
  - Any write that would have completed that cycle is discarded: the address is not incremented.
- rst asserted mid-stream returns all state to reset values immediately (asynchronous); in-flight words are lost.

Test Plan:
1. After reset, push LOAD rd=5 rs1=2 imm=8 with mem_ready=1.
   - Response: mem_we=1 the next cycle, mem_wdata=0x00812283, mem_addr=0x000; mem_addr=0x004 after the write.
2. Push STORE rs2=6 rs1=2 imm=12, then OP rd=3 rs1=1 rs2=2 funct3=0 alt=0, then the same OP with alt=1.
   - Response: words 0x00612623, 0x002081B3, 0x402081B3 at addresses 0x000, 0x004, 0x008.
3. BRANCH rs1=0 rs2=0 funct3=0 imm=8 -> 0x00000463. Also BRANCH imm=13'h1FF8 (-8) -> 0xFE000CE3.
4. Backpressure: mem_ready=0, push 5 bundles.
   - count reaches 4 and in_ready=0; the 5th is held.
   - mem_wdata/mem_addr stay stable.
   - Then mem_ready=1: 5 writes drain in order; in_ready rises one cycle after the first pop.
5. Push in_cls=6, then a valid OPIMM.
   - err pulses for one cycle; count stays 0 for the illegal bundle.
   - Only the OPIMM is written, at address 0x000.
6. With 3 queued words, mem_addr=0xFF8 and ADDR_W=12: the writes go to 0xFF8, 0xFFC, 0x000.
   - Then clear together with push and mem_ready: count=0, mem_addr=BASE, and no write counted.
   - Repeat with rst mid-drain: immediate return to reset values.
